// File: rtl/frequency_divisor_generator.sv
// frequency_divisor_generator: key-adjustable divisor register saturating within [min_divisor, max_divisor]
module frequency_divisor_generator #(
  parameter logic [31:0] max_divisor     = 32'd2272,
  parameter logic [31:0] min_divisor     = 32'd568,
  parameter logic [31:0] default_divisor = (min_divisor + max_divisor) / 2,
  parameter logic [31:0] step            = 32'd1,
  parameter logic [31:0] step_interval   = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_0,
  input  logic        key_1,
  input  logic        key_2,
  output logic [31:0] frequency_divisor
);
  logic [31:0] div_q, div_d, cnt_q, cnt_d;
  logic [32:0] inc, lo;
  logic adj, fire;
  always_comb begin
    adj   = (key_0 ^ key_1) & ~key_2;
    fire  = adj & (cnt_q == step_interval - 32'd1);
    inc   = {1'b0, div_q} + {1'b0, step};
    lo    = {1'b0, min_divisor} + {1'b0, step};
    cnt_d = (adj & ~fire) ? cnt_q + 32'd1 : 32'd0;
    div_d = key_2 ? default_divisor :
            !fire ? div_q :
            key_0 ? (({1'b0, div_q} < lo) ? min_divisor : div_q - step) :
                    ((inc > {1'b0, max_divisor}) ? max_divisor : inc[31:0]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= default_divisor;
      cnt_q <= 32'd0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
  assign frequency_divisor = div_q;
endmodule

// File: tb/tb_frequency_divisor_generator.sv
// tb_frequency_divisor_generator: vector table, corner sequences and random run against a run-length model
module tb_frequency_divisor_generator;
  logic clk = 1'b0, reset = 1'b0, key_0 = 1'b0, key_1 = 1'b0, key_2 = 1'b0;
  logic [31:0] fd1, fd4;
  int pass_cnt = 0, total_cnt = 0;
  int m_div[2], m_run[2];
  int si[2] = '{1, 4};

  typedef struct {
    logic r, k0, k1, k2;
    int   exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  frequency_divisor_generator #(.max_divisor(32'd1140), .min_divisor(32'd1130),
    .default_divisor(32'd1135), .step(32'd1), .step_interval(32'd1)) dut (
    .clk(clk), .reset(reset), .key_0(key_0), .key_1(key_1), .key_2(key_2), .frequency_divisor(fd1));

  frequency_divisor_generator #(.max_divisor(32'd1140), .min_divisor(32'd1130),
    .default_divisor(32'd1135), .step(32'd1), .step_interval(32'd4)) dut4 (
    .clk(clk), .reset(reset), .key_0(key_0), .key_1(key_1), .key_2(key_2), .frequency_divisor(fd4));

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic r, input logic a, input logic b, input logic c, input int e);
    vec_t v;
    v.r = r; v.k0 = a; v.k1 = b; v.k2 = c; v.exp = e;
    vecs.push_back(v);
  endtask

  // Model counts how long the current single-key press has lasted; every si-th cycle of it adjusts.
  task automatic model_edge(input logic r, input logic a, input logic b, input logic c);
    for (int k = 0; k < 2; k++) begin
      if (r || c) begin
        m_div[k] = 1135; m_run[k] = 0;
      end else if (a != b) begin
        m_run[k]++;
        if (m_run[k] % si[k] == 0)
          m_div[k] = a ? ((m_div[k] - 1 < 1130) ? 1130 : m_div[k] - 1)
                       : ((m_div[k] + 1 > 1140) ? 1140 : m_div[k] + 1);
      end else m_run[k] = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic a, input logic b, input logic c);
    reset = r; key_0 = a; key_1 = b; key_2 = c;
    @(posedge clk);
    model_edge(r, a, b, c);
    #1;
    chk("model_si1", int'(fd1), m_div[0]);
    chk("model_si4", int'(fd4), m_div[1]);
  endtask

  initial begin
    add(1, 0, 0, 0, 1135);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1135);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, (i < 5) ? 1134 - i : 1130);
    for (int i = 0; i < 12; i++) add(0, 0, 1, 0, (i < 10) ? 1131 + i : 1140);
    for (int i = 0; i < 10; i++) add(0, 1, 1, 0, 1140);
    add(0, 1, 1, 1, 1135);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 1135);
    add(0, 0, 0, 0, 1135);
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].k0, vecs[i].k1, vecs[i].k2);
      chk($sformatf("vec%0d", i), int'(fd1), vecs[i].exp);
    end

    // step_interval=4 hold with reset landing mid-interval
    cycle(1, 0, 0, 0);
    chk("si4_reset", int'(fd4), 1135);
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 1, 0);
      chk($sformatf("si4_hold%0d", i), int'(fd4), (i >= 4) ? 1136 : 1135);
    end
    cycle(1, 0, 1, 0);
    chk("si4_mid_reset", int'(fd4), 1135);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 0);
      chk($sformatf("si4_restart%0d", i), int'(fd4), (i >= 8) ? 1137 : (i >= 4) ? 1136 : 1135);
    end

    // random run: occasional reset/restore, frequent long holds
    for (int i = 0; i < 400; i++) begin
      logic r, a, b, c;
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 3) == 0);
      if (i % 80 >= 40) begin a = ~a; b = ~b; end
      cycle(r, a, b, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
